// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a command/response stream
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    m3_axi_aclk,
  input  logic                    m3_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RESP_WIDTH-1:0]   rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m3_axi_awaddr,
  output logic                    m3_axi_awvalid,
  input  logic                    m3_axi_awready,
  output logic [DATA_WIDTH-1:0]   m3_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m3_axi_wstrb,
  output logic                    m3_axi_wvalid,
  input  logic                    m3_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m3_axi_bresp,
  input  logic                    m3_axi_bvalid,
  output logic                    m3_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m3_axi_araddr,
  output logic                    m3_axi_arvalid,
  input  logic                    m3_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m3_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m3_axi_rresp,
  input  logic                    m3_axi_rvalid,
  output logic                    m3_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_RD   = 3'd3,
    S_RD_R = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    write_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    cmd_ready_q;
  logic                    accept;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic                    capture_b;
  logic                    capture_r;
  logic                    busy;
  logic                    timeout;
  logic                    tmo_fire;

  assign busy = (state == S_WR) || (state == S_WR_B) || (state == S_RD) || (state == S_RD_R);

  // Valids are derived from registered state only, so they cannot glitch or
  // change while waiting for a ready.
  assign m3_axi_awvalid = (state == S_WR) && !aw_done;
  assign m3_axi_wvalid  = (state == S_WR) && !w_done;
  assign m3_axi_bready  = (state == S_WR_B);
  assign m3_axi_arvalid = (state == S_RD);
  assign m3_axi_rready  = (state == S_RD_R);
  assign rsp_valid      = (state == S_RSP);

  assign m3_axi_awaddr = addr_q;
  assign m3_axi_araddr = addr_q;
  assign m3_axi_wdata  = wdata_q;
  assign m3_axi_wstrb  = wstrb_q;
  assign rsp_write     = write_q;
  assign cmd_ready     = cmd_ready_q;

  assign accept    = cmd_valid && cmd_ready_q && (state == S_IDLE);
  assign aw_hs     = m3_axi_awvalid && m3_axi_awready;
  assign w_hs      = m3_axi_wvalid && m3_axi_wready;
  assign ar_hs     = m3_axi_arvalid && m3_axi_arready;
  assign capture_b = m3_axi_bready && m3_axi_bvalid;
  assign capture_r = m3_axi_rready && m3_axi_rvalid;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Restarts on every state change so each channel phase gets its own budget.
  always_ff @(posedge m3_axi_aclk) begin
    if (m3_axi_areset || (state != next_state)) begin
      tmo_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = busy && (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge m3_axi_aclk) begin
    if (m3_axi_areset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmo_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = cmd_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (aw_done && w_done) begin
          next_state = S_WR_B;
        end else if (timeout) begin
          next_state = S_RSP;
          tmo_fire   = 1'b1;
        end
      end
      S_WR_B: begin
        if (capture_b) begin
          next_state = S_RSP;
        end else if (timeout) begin
          next_state = S_RSP;
          tmo_fire   = 1'b1;
        end
      end
      S_RD: begin
        if (ar_hs) begin
          next_state = S_RD_R;
        end else if (timeout) begin
          next_state = S_RSP;
          tmo_fire   = 1'b1;
        end
      end
      S_RD_R: begin
        if (capture_r) begin
          next_state = S_RSP;
        end else if (timeout) begin
          next_state = S_RSP;
          tmo_fire   = 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge m3_axi_aclk) begin
    if (m3_axi_areset) begin
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
    end else begin
      // Registered so the next command waits one cycle after the rsp handshake.
      cmd_ready_q <= (next_state == S_IDLE);
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          w_done <= 1'b1;
        end
      end
      if (capture_b) begin
        rsp_rdata <= '0;
        rsp_resp  <= m3_axi_bresp;
      end else if (capture_r) begin
        rsp_rdata <= m3_axi_rdata;
        rsp_resp  <= m3_axi_rresp;
      end else if (tmo_fire) begin
        rsp_rdata <= '0;
        rsp_resp  <= RESP_WIDTH'(2);
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - scoreboard bench for axi_lite_cmd_master with a behavioural AXI4-Lite slave
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;

  typedef struct packed {
    logic        w;
    logic [31:0] rdata;
    logic [2:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_resp;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_cmd_master dut (
    .m3_axi_aclk    (clk),
    .m3_axi_areset  (areset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_wstrb      (cmd_wstrb),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_write      (rsp_write),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .m3_axi_awaddr  (awaddr),
    .m3_axi_awvalid (awvalid),
    .m3_axi_awready (awready),
    .m3_axi_wdata   (wdata),
    .m3_axi_wstrb   (wstrb),
    .m3_axi_wvalid  (wvalid),
    .m3_axi_wready  (wready),
    .m3_axi_bresp   (bresp),
    .m3_axi_bvalid  (bvalid),
    .m3_axi_bready  (bready),
    .m3_axi_araddr  (araddr),
    .m3_axi_arvalid (arvalid),
    .m3_axi_arready (arready),
    .m3_axi_rdata   (rdata),
    .m3_axi_rresp   (rresp),
    .m3_axi_rvalid  (rvalid),
    .m3_axi_rready  (rready)
  );

  // Slave: addresses at or above 0xF0 answer with resp 3'b011.
  function automatic logic [2:0] slv_resp(input logic [7:0] a);
    return (a >= 8'hF0) ? 3'b011 : 3'b000;
  endfunction

  logic        aw_en = 1'b1, w_en = 1'b1, ar_en = 1'b1, b_en = 1'b1;
  logic        aw_got, w_got, b_pend;
  logic [7:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [2:0]  b_resp_q;
  logic [31:0] slv_mem [64];
  logic        slv_ha, slv_hw;
  logic [7:0]  slv_a;
  logic [31:0] slv_d;
  logic [3:0]  slv_s;

  assign awready = aw_en;
  assign wready  = w_en;
  assign arready = ar_en;
  assign bvalid  = b_pend && b_en;
  assign bresp   = b_resp_q;
  assign slv_ha  = aw_got || (awvalid && awready);
  assign slv_hw  = w_got || (wvalid && wready);
  assign slv_a   = aw_got ? aw_addr_q : awaddr;
  assign slv_d   = w_got ? w_data_q : wdata;
  assign slv_s   = w_got ? w_strb_q : wstrb;

  always @(posedge clk) begin
    if (areset) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; b_resp_q <= 3'b0;
      rvalid <= 1'b0; rdata <= 32'h0; rresp <= 3'b0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; end
      if (slv_ha && slv_hw && !b_pend) begin
        for (int i = 0; i < 4; i++)
          if (slv_s[i]) slv_mem[slv_a[7:2]][8*i +: 8] <= slv_d[8*i +: 8];
        b_pend <= 1'b1; b_resp_q <= slv_resp(slv_a);
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) b_pend <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= slv_mem[araddr[7:2]]; rresp <= slv_resp(araddr);
      end
    end
  end

  int          n_checks = 0, n_fail = 0, n_rsp = 0, n_push = 0, n_drop = 0;
  exp_t        sb [$];
  logic [31:0] model_mem [64];
  logic        stab_en = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!areset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", rsp_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_rsp++;
        check_eq("rsp_write", rsp_write, e.w);
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_resp", rsp_resp, e.resp);
      end
    end
  end

  logic        aw_pend = 0, w_pend = 0, ar_pend = 0, r_pend = 0;
  logic [7:0]  aw_prev, ar_prev;
  logic [31:0] w_prev, r_prev;
  always @(negedge clk) begin
    if (areset || !stab_en) begin
      aw_pend <= 0; w_pend <= 0; ar_pend <= 0; r_pend <= 0;
    end else begin
      if (aw_pend) check_eq("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
      if (ar_pend) check_eq("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
      if (w_pend) begin
        check_eq("w_stable_valid", wvalid, 1);
        check_eq("w_stable_data", wdata, w_prev);
      end
      if (r_pend) begin
        check_eq("rsp_stable_valid", rsp_valid, 1);
        check_eq("rsp_stable_rdata", rsp_rdata, r_prev);
      end
      aw_pend <= awvalid && !awready; aw_prev <= awaddr;
      ar_pend <= arvalid && !arready; ar_prev <= araddr;
      w_pend  <= wvalid && !wready;   w_prev  <= wdata;
      r_pend  <= rsp_valid && !rsp_ready; r_prev <= rsp_rdata;
    end
  end

  // Entered and left at posedge+1; expectation pushed at acceptance.
  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic tmo);
    int   n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("cmd_accept_timeout", n, 0);
    e.w = w;
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) model_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
      e.rdata = 32'h0;
    end else begin
      e.rdata = model_mem[a[7:2]];
    end
    e.resp = slv_resp(a);
    if (tmo) begin
      e.rdata = 32'h0;
      e.resp  = 3'b010;
    end
    sb.push_back(e);
    n_push++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("rsp_wait_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, hi;
    for (int i = 0; i < 64; i++) begin
      slv_mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_resp", rsp_resp, 0);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check_eq("cmd_ready_at_release", cmd_ready, 0);
    @(negedge clk);
    check_eq("cmd_ready_after_release", cmd_ready, 1);
    @(posedge clk);
    #1;

    // 1: zero-wait write, aw and w handshake together, four-cycle latency
    send_cmd(1'b1, 8'h00, 32'd25, 4'hF, 1'b0);
    lat = 0; k = 0;
    while (lat == 0 && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) check_eq("t1_aw_w_same_cycle", {awvalid, wvalid, awready, wready}, 4'hF);
      if (rsp_valid) lat = k;
    end
    check_eq("t1_latency", lat, 4);
    @(posedge clk);
    #1;
    wait_rsp();

    // 2: awready three cycles ahead of wready
    w_en = 1'b0;
    send_cmd(1'b1, 8'h04, 32'd34, 4'hF, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check_eq("t2_wvalid_held", wvalid, 1);
      if (j > 1) check_eq("t2_awvalid_dropped", awvalid, 0);
    end
    @(posedge clk);
    #1 w_en = 1'b1;
    wait_rsp();
    check_eq("t2_single_rsp", n_rsp, 2);

    // 3: read back
    send_cmd(1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
    wait_rsp();

    // partial strobe merge
    send_cmd(1'b1, 8'h08, 32'hA5A5_1234, 4'hF, 1'b0);
    wait_rsp();
    send_cmd(1'b1, 8'h08, 32'hFFFF_FFFF, 4'b0011, 1'b0);
    wait_rsp();

    // 4: read with response back-pressure
    rsp_ready = 1'b0;
    send_cmd(1'b0, 8'h08, 32'h0, 4'h0, 1'b0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_rsp_valid_seen", rsp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("t4_rsp_valid_hold", rsp_valid, 1);
      check_eq("t4_cmd_ready_low", cmd_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp();

    // slave error response passthrough at top of the address map
    send_cmd(1'b1, 8'hFC, 32'h0000_0001, 4'hF, 1'b0);
    wait_rsp();
    send_cmd(1'b0, 8'hFC, 32'h0, 4'h0, 1'b0);
    wait_rsp();

    // 5: reset while waiting for bvalid
    b_en = 1'b0;
    send_cmd(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    k = 0;
    while (!bready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("t5_in_wr_b", bready, 1);
    @(posedge clk);
    #1 areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_valids_low", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    check_eq("t5_cmd_ready_low", cmd_ready, 0);
    sb.delete();
    n_drop++;
    @(posedge clk);
    #1 areset = 1'b0;
    b_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("t5_no_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    send_cmd(1'b1, 8'h10, 32'h1357_9BDF, 4'hF, 1'b0);
    wait_rsp();
    send_cmd(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
    wait_rsp();

`ifdef AXI_MASTER_TIMEOUT_EN
    // 6: read address never accepted
    ar_en = 1'b0;
    stab_en = 1'b0;
    send_cmd(1'b0, 8'h04, 32'h0, 4'h0, 1'b1);
    hi = 0; k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
      if (arvalid) hi++;
    end
    check_eq("t6_arvalid_cycles", hi, 64);
    check_eq("t6_arvalid_low", arvalid, 0);
    @(posedge clk);
    #1;
    wait_rsp();
    ar_en = 1'b1;
    stab_en = 1'b1;
`else
    hi = 0;
`endif

    check_eq("rsp_count", n_rsp, n_push - n_drop);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
